ps2_host_tx: RTL
================

# ps2_host_tx

Host-to-device transmitter for the PS/2 keyboard port. It sends one command byte to the keyboard, for example 0xED (set LEDs) followed by an LED mask that mirrors the Caps Lock state. It drives the PS/2 clock and data lines as open-drain enables, follows the device-generated clock, appends odd parity and the stop bit, and checks the device acknowledge. It sits beside the scan-code receive path, and the 8051 SFR layer issues commands through a start/done handshake.

## Interface
- INHIBIT_CYCLES, 10000: number of i_clk cycles the PS/2 clock is held low before request-to-send (100 µs at 100 MHz).
- TIMEOUT_CYCLES, 2000000: watchdog limit in i_clk cycles, counted from entry to RTS (20 ms at 100 MHz).
- i_clk  in  1  system clock.
- i_rst_n  in  1  asynchronous, active-low reset.
- i_tx_byte  in  8  command byte, sampled on the cycle i_tx_start is accepted.
- i_tx_start  in  1  request pulse; accepted only when o_busy=0.
- o_busy  out  1  high in every state except IDLE.
- o_tx_done  out  1  one-cycle pulse on successful, acknowledged transfer.
- o_tx_err  out  1  one-cycle pulse on NACK or timeout.
- i_ps2_clk  in  1  raw PS/2 clock pin level.
- i_ps2_data  in  1  raw PS/2 data pin level.
- o_ps2_clk_oe  out  1  1 = pull PS/2 clock low; 0 = release.
- o_ps2_data_oe  out  1  1 = pull PS/2 data low; 0 = release.

## Operation
- **Input conditioning**
  - i_ps2_clk and i_ps2_data each pass through a 2-flop synchronizer.
  - A falling edge is detected from the synchronized clock and its registered previous value.
- **Load on accept**
  - Latch i_tx_byte into an 8-bit shift register.
  - Compute parity = ~^i_tx_byte, so the 9 bits together carry an odd number of ones.
- **State machine**
  - IDLE: all outputs are 0. On accepted start, go to INHIBIT and clear the cycle counter.
  - INHIBIT: clk_oe=1, data_oe=0. After INHIBIT_CYCLES cycles, go to RTS.
  - RTS: clk_oe=0, data_oe=1, which is the start bit. Clear the edge counter (4 bits) and the watchdog, then go to XFER.
  - XFER: act on each synchronized falling edge, counting k = 1..11.
    - k=1..8: data_oe = ~bit[k-1], LSB first.
    - k=9: data_oe = ~parity.
    - k=10: data_oe=0, which releases the stop bit.
    - k=11: sample synchronized data. If it is 0 (ACK), go to WAIT_IDLE. If it is 1 (NACK), pulse o_tx_err and go to IDLE.
  - WAIT_IDLE: wait until synchronized clock=1 and data=1, then pulse o_tx_done and go to IDLE.
- **Watchdog**
  - Applies in RTS, XFER and WAIT_IDLE.
  - On expiry: release both lines, pulse o_tx_err, go to IDLE.
- **Edge and pulse rules**
  - Falling edges seen outside XFER are ignored.
  - o_tx_done and o_tx_err are mutually exclusive.
  - o_busy falls in the same cycle the done/err pulse is high.
- **Boundary conditions**
  - i_tx_start while busy: ignored, and the byte is not relatched.
  - i_tx_start in the same cycle the block returns to IDLE: ignored, because o_busy is still high in that cycle.
  - Reset asserted mid-transfer: all outputs go to 0 immediately (asynchronously) and the state returns to IDLE. No pulse is issued.

## Timing
- Reset value of every output is 0.
- o_busy rises the cycle after an accepted i_tx_start. clk_oe rises in that same cycle.
- clk_oe stays high for exactly INHIBIT_CYCLES cycles.
- data_oe asserts in the first cycle clk_oe is 0. There is no cycle where both lines are released between INHIBIT and RTS.
- Pin-to-action latency is 3 i_clk cycles: 2 synchronizer stages plus 1 edge-detect stage. Data changes while the PS/2 clock is low, well before the device samples on the rising edge.
- o_tx_done asserts 3 cycles after both pins read high in WAIT_IDLE.

## Configuration
- PS2_TX_TIMEOUT_EN defined:
  - The watchdog and the TIMEOUT_CYCLES counter are built.
  - Timeout produces o_tx_err as described above.
- PS2_TX_TIMEOUT_EN undefined:
  - No watchdog logic is built, and TIMEOUT_CYCLES is unused.
  - The block waits indefinitely for device clocks; o_tx_err comes only from NACK.

## Test plan
- Send 0xED; the device model clocks at 12.5 kHz and ACKs -> clk_oe held for INHIBIT_CYCLES, data bits 1,0,1,1,0,1,1,1, parity 1, stop released, one o_tx_done pulse, no o_tx_err.
- Send 0x01 -> parity bit 0 (data_oe=1 on edge 9); send 0x00 -> parity bit 1; both complete with o_tx_done.
- Device leaves data high at edge 11 -> one o_tx_err pulse, no o_tx_done, both oe=0, o_busy=0.
- With PS2_TX_TIMEOUT_EN and TIMEOUT_CYCLES=1000, the device never clocks -> o_tx_err exactly 1000 cycles after RTS entry, both oe=0.
- Second i_tx_start with 0x55 during a 0xF4 transfer -> ignored, bits on the wire are 0xF4's.
- Assert i_rst_n low at edge 5 of a transfer -> o_ps2_clk_oe, o_ps2_data_oe and o_busy are 0 before the next i_clk edge, no done or err pulse. After release, a new 0xED transfer completes normally.

Source files
------------

// File: rtl/ps2_host_tx_if.sv
// Command handshake and PS/2 pin bundle for the PS/2 host transmitter.
// slave: the transmitter; master: the SFR layer together with the pad ring.
interface ps2_host_tx_if;
  logic [7:0] i_tx_byte;
  logic       i_tx_start;
  logic       o_busy;
  logic       o_tx_done;
  logic       o_tx_err;
  logic       i_ps2_clk;
  logic       i_ps2_data;
  logic       o_ps2_clk_oe;
  logic       o_ps2_data_oe;

  modport slave (
    input  i_tx_byte, i_tx_start, i_ps2_clk, i_ps2_data,
    output o_busy, o_tx_done, o_tx_err, o_ps2_clk_oe, o_ps2_data_oe
  );

  modport master (
    output i_tx_byte, i_tx_start, i_ps2_clk, i_ps2_data,
    input  o_busy, o_tx_done, o_tx_err, o_ps2_clk_oe, o_ps2_data_oe
  );
endinterface

// File: rtl/ps2_host_tx.sv
// PS/2 host-to-device command transmitter with open-drain clock/data enables.
// Define PS2_TX_TIMEOUT_EN to build the RTS-to-idle watchdog (TIMEOUT_CYCLES).
module ps2_host_tx #(
  parameter int unsigned INHIBIT_CYCLES = 10000,
  parameter int unsigned TIMEOUT_CYCLES = 2000000
) (
  input logic          i_clk,
  input logic          i_rst_n,
  ps2_host_tx_if.slave bus
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_INHIBIT,
    S_RTS,
    S_XFER,
    S_WAIT_IDLE
  } state_e;

  localparam int unsigned      INH_W    = $clog2(INHIBIT_CYCLES + 1);
  localparam logic [INH_W-1:0] INH_LAST = INH_W'(INHIBIT_CYCLES - 1);

  state_e           state_q, state_d;
  logic [INH_W-1:0] inh_cnt_q, inh_cnt_d;
  logic [8:0]       sr_q, sr_d;
  logic [3:0]       edge_q, edge_d;
  logic             data_oe_q, data_oe_d;
  logic             done_q, done_d;
  logic             err_q, err_d;

  logic clk_s1_q, clk_s2_q, clk_prev_q;
  logic dat_s1_q, dat_s2_q;
  logic ps2_fall;
  logic wdt_active;
  logic timeout;

  // Lines idle high, so the synchronizers reset to 1 to avoid a false edge.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      clk_s1_q   <= 1'b1;
      clk_s2_q   <= 1'b1;
      clk_prev_q <= 1'b1;
      dat_s1_q   <= 1'b1;
      dat_s2_q   <= 1'b1;
    end else begin
      clk_s1_q   <= bus.i_ps2_clk;
      clk_s2_q   <= clk_s1_q;
      clk_prev_q <= clk_s2_q;
      dat_s1_q   <= bus.i_ps2_data;
      dat_s2_q   <= dat_s1_q;
    end
  end

  assign ps2_fall   = clk_prev_q & ~clk_s2_q;
  assign wdt_active = (state_q == S_RTS) || (state_q == S_XFER) || (state_q == S_WAIT_IDLE);

`ifdef PS2_TX_TIMEOUT_EN
  localparam int unsigned      WDT_W    = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [WDT_W-1:0] WDT_LAST = WDT_W'(TIMEOUT_CYCLES - 1);

  logic [WDT_W-1:0] wdt_q, wdt_d;

  // Cleared while inhibiting so the count starts at zero on the RTS cycle.
  always_comb begin
    wdt_d = wdt_q;
    if (state_q == S_INHIBIT) begin
      wdt_d = '0;
    end else if (wdt_active) begin
      wdt_d = wdt_q + 1'b1;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      wdt_q <= '0;
    end else begin
      wdt_q <= wdt_d;
    end
  end

  assign timeout = wdt_active && (wdt_q == WDT_LAST);
`else
  logic unused_wdt_cfg;
  assign unused_wdt_cfg = ^TIMEOUT_CYCLES ^ wdt_active;
  assign timeout        = 1'b0;
`endif

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q   <= S_IDLE;
      inh_cnt_q <= '0;
      sr_q      <= '0;
      edge_q    <= '0;
      data_oe_q <= 1'b0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      inh_cnt_q <= inh_cnt_d;
      sr_q      <= sr_d;
      edge_q    <= edge_d;
      data_oe_q <= data_oe_d;
      done_q    <= done_d;
      err_q     <= err_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    inh_cnt_d = inh_cnt_q;
    sr_d      = sr_q;
    edge_d    = edge_q;
    data_oe_d = data_oe_q;
    done_d    = 1'b0;
    err_d     = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (bus.i_tx_start) begin
          state_d   = S_INHIBIT;
          inh_cnt_d = '0;
          sr_d      = {~^bus.i_tx_byte, bus.i_tx_byte};
        end
      end
      S_INHIBIT: begin
        if (inh_cnt_q == INH_LAST) begin
          state_d = S_RTS;
        end else begin
          inh_cnt_d = inh_cnt_q + 1'b1;
        end
      end
      S_RTS: begin
        edge_d    = '0;
        data_oe_d = 1'b1;
        state_d   = S_XFER;
      end
      S_XFER: begin
        // edge_q holds the count before this edge: 0..8 shift data+parity,
        // 9 releases the stop bit, 10 samples the device acknowledge.
        if (ps2_fall) begin
          edge_d = edge_q + 4'd1;
          if (edge_q < 4'd9) begin
            data_oe_d = ~sr_q[0];
            sr_d      = {1'b0, sr_q[8:1]};
          end else if (edge_q == 4'd9) begin
            data_oe_d = 1'b0;
          end else begin
            data_oe_d = 1'b0;
            if (dat_s2_q) begin
              err_d   = 1'b1;
              state_d = S_IDLE;
            end else begin
              state_d = S_WAIT_IDLE;
            end
          end
        end
      end
      S_WAIT_IDLE: begin
        if (clk_s2_q && dat_s2_q) begin
          done_d  = 1'b1;
          state_d = S_IDLE;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    if (timeout) begin
      state_d   = S_IDLE;
      data_oe_d = 1'b0;
      done_d    = 1'b0;
      err_d     = 1'b1;
    end
  end

  assign bus.o_busy        = (state_q != S_IDLE);
  assign bus.o_ps2_clk_oe  = (state_q == S_INHIBIT);
  assign bus.o_ps2_data_oe = (state_q == S_RTS) || ((state_q == S_XFER) && data_oe_q);
  assign bus.o_tx_done     = done_q;
  assign bus.o_tx_err      = err_q;

endmodule
